// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] EXC_IMISALIGN = 4'd0;
  localparam logic [CODE_W-1:0] EXC_ILLEGAL   = 4'd2;
  localparam logic [CODE_W-1:0] EXC_BREAK     = 4'd3;
  localparam logic [CODE_W-1:0] EXC_LMISALIGN = 4'd4;
  localparam logic [CODE_W-1:0] EXC_SMISALIGN = 4'd6;
  localparam logic [CODE_W-1:0] EXC_ECALL_M   = 4'd11;

  localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser for an asynchronous level-sensitive interrupt line.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, d});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt arbiter: records cause state, updates mstatus
// and redirects fetch through a valid/ready handshake.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              insn_done,
  input  logic [XLEN-1:0]   insn_pc,
  input  logic              exc_valid,
  input  logic [CODE_W-1:0] exc_code,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic              mret,
  input  logic              ext_irq,
  input  logic              sw_irq,
  input  logic              time_compare,
  input  logic [XLEN-1:0]   mstatus,
  input  logic [XLEN-1:0]   mie,
  input  logic [XLEN-1:0]   mtvec,
  output logic [XLEN-1:0]   mip,
  output logic [XLEN-1:0]   mcause,
  output logic [XLEN-1:0]   mepc,
  output logic [XLEN-1:0]   mbadaddr,
  output logic              mstatus_we,
  output logic [XLEN-1:0]   mstatus_next,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready
);

  localparam int unsigned CAUSE_LO_W = XLEN - 1;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mbadaddr_q, mbadaddr_d;
  logic              mstatus_we_q, mstatus_we_d;
  logic [XLEN-1:0]   mstatus_next_q, mstatus_next_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic              meip;
  logic [XLEN-1:0]   pend;
  logic              pend_any;
  logic [CODE_W-1:0] irq_code;
  logic [XLEN-1:0]   tvec_base;
  logic [XLEN-1:0]   irq_pc;
  logic [XLEN-1:0]   trap_mstatus;
  logic [XLEN-1:0]   mret_mstatus;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (ext_irq),
    .q      (meip)
  );

  // Pending bits, global-enable gating, priority MEI > MSI > MTI, vector target
  always_comb begin
    mip           = '0;
    mip[MIP_MEIP] = meip;
    mip[MIP_MTIP] = time_compare;
    mip[MIP_MSIP] = sw_irq;

    pend     = (mip & mie) & {XLEN{mstatus[MSTATUS_MIE]}};
    pend_any = |pend;

    irq_code = IRQ_MTI;
    if (pend[MIP_MSIP]) irq_code = IRQ_MSI;
    if (pend[MIP_MEIP]) irq_code = IRQ_MEI;

    tvec_base = {mtvec[XLEN-1:2], 2'b00};
    irq_pc    = (mtvec[1:0] == 2'b01) ? tvec_base + XLEN'({irq_code, 2'b00})
                                      : tvec_base;
  end

  always_comb begin
    trap_mstatus                                 = mstatus;
    trap_mstatus[MSTATUS_MPIE]                   = mstatus[MSTATUS_MIE];
    trap_mstatus[MSTATUS_MIE]                    = 1'b0;
    trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mret_mstatus                                 = mstatus;
    mret_mstatus[MSTATUS_MIE]                    = mstatus[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE]                   = 1'b1;
    mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    state_d          = state_q;
    mcause_d         = mcause_q;
    mepc_d           = mepc_q;
    mbadaddr_d       = mbadaddr_q;
    mstatus_we_d     = 1'b0;
    mstatus_next_d   = mstatus_next_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      IDLE: begin
        if (insn_done) begin
          if (exc_valid) begin
            mcause_d         = XLEN'(exc_code);
            mepc_d           = insn_pc;
            mbadaddr_d       = exc_tval;
            redirect_pc_d    = tvec_base;
            mstatus_we_d     = 1'b1;
            mstatus_next_d   = trap_mstatus;
            redirect_valid_d = 1'b1;
            state_d          = REDIRECT;
          end else if (pend_any) begin
            mcause_d         = {1'b1, CAUSE_LO_W'(irq_code)};
            mepc_d           = insn_pc + XLEN'(4);
            mbadaddr_d       = '0;
            redirect_pc_d    = irq_pc;
            mstatus_we_d     = 1'b1;
            mstatus_next_d   = trap_mstatus;
            redirect_valid_d = 1'b1;
            state_d          = REDIRECT;
          end else if (mret) begin
            redirect_pc_d    = mepc_q;
            mstatus_we_d     = 1'b1;
            mstatus_next_d   = mret_mstatus;
            redirect_valid_d = 1'b1;
            state_d          = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        // Everything else waits until fetch has taken the new PC
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      mcause_q         <= '0;
      mepc_q           <= '0;
      mbadaddr_q       <= '0;
      mstatus_we_q     <= 1'b0;
      mstatus_next_q   <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mcause_q         <= mcause_d;
      mepc_q           <= mepc_d;
      mbadaddr_q       <= mbadaddr_d;
      mstatus_we_q     <= mstatus_we_d;
      mstatus_next_q   <= mstatus_next_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign mcause         = mcause_q;
  assign mepc           = mepc_q;
  assign mbadaddr       = mbadaddr_q;
  assign mstatus_we     = mstatus_we_q;
  assign mstatus_next   = mstatus_next_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected trap records are queued at each
// boundary and compared when the redirect request appears.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        insn_done;
  logic [31:0] insn_pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic        mret;
  logic        ext_irq;
  logic        sw_irq;
  logic        time_compare;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mip;
  logic [31:0] mcause;
  logic [31:0] mepc;
  logic [31:0] mbadaddr;
  logic        mstatus_we;
  logic [31:0] mstatus_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic [31:0] rpc;
    logic [31:0] mst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  trap_ctrl #(.XLEN(32), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .insn_done      (insn_done),
    .insn_pc        (insn_pc),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .ext_irq        (ext_irq),
    .sw_irq         (sw_irq),
    .time_compare   (time_compare),
    .mstatus        (mstatus),
    .mie            (mie),
    .mtvec          (mtvec),
    .mip            (mip),
    .mcause         (mcause),
    .mepc           (mepc),
    .mbadaddr       (mbadaddr),
    .mstatus_we     (mstatus_we),
    .mstatus_next   (mstatus_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] e, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] m);
    exp_t x;
    x.cause = c; x.epc = e; x.badaddr = b; x.rpc = r; x.mst = m;
    sb.push_back(x);
  endtask

  task automatic boundary(input logic [31:0] pc, input logic ev, input logic [3:0] code,
                          input logic [31:0] tval, input logic is_mret);
    insn_done = 1'b1;
    insn_pc   = pc;
    exc_valid = ev;
    exc_code  = code;
    exc_tval  = tval;
    mret      = is_mret;
    tick();
    insn_done = 1'b0;
    exc_valid = 1'b0;
    mret      = 1'b0;
  endtask

  task automatic expect_redirect();
    exp_t e;
    int   n = 0;
    while (!redirect_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("redirect_valid", 32'(redirect_valid), 32'd1);
    check_eq("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("mcause", mcause, e.cause);
      check_eq("mepc", mepc, e.epc);
      check_eq("mbadaddr", mbadaddr, e.badaddr);
      check_eq("redirect_pc", redirect_pc, e.rpc);
      check_eq("mstatus_we", 32'(mstatus_we), 32'd1);
      check_eq("mstatus_next", mstatus_next, e.mst);
    end
  endtask

  // Hold off the core for n cycles while throwing ignored boundaries at the DUT
  task automatic accept(input int n, input logic [31:0] rpc, input logic [31:0] cause);
    for (int i = 0; i < n; i++) begin
      insn_done = 1'b1;
      exc_valid = 1'b1;
      exc_code  = 4'd5;
      insn_pc   = 32'h999;
      tick();
      check_eq("hold_valid", 32'(redirect_valid), 32'd1);
      check_eq("hold_pc", redirect_pc, rpc);
      check_eq("hold_cause", mcause, cause);
      check_eq("hold_we", 32'(mstatus_we), 32'd0);
    end
    insn_done      = 1'b0;
    exc_valid      = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check_eq("accept_valid", 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; insn_done = 1'b0; insn_pc = '0; exc_valid = 1'b0; exc_code = '0;
    exc_tval = '0; mret = 1'b0; ext_irq = 1'b0; sw_irq = 1'b0; time_compare = 1'b0;
    mstatus = '0; mie = '0; mtvec = '0; redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mip", mip, 32'h0);
    check_eq("rst_valid", 32'(redirect_valid), 32'd0);
    check_eq("rst_we", 32'(mstatus_we), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_valid", 32'(redirect_valid), 32'd0);
    end
    check_eq("idle_we", 32'(mstatus_we), 32'd0);

    // Synchronous exception, held off by the core for three cycles
    mstatus = 32'h8; mtvec = 32'h80;
    push(32'h2, 32'h100, 32'hDEADBEEF, 32'h80, 32'h1880);
    boundary(32'h100, 1'b1, 4'd2, 32'hDEADBEEF, 1'b0);
    expect_redirect();
    accept(3, 32'h80, 32'h2);

    // Vectored timer interrupt
    mie = 32'h80; time_compare = 1'b1; mtvec = 32'h201;
    tick();
    check_eq("mip_mtip", mip, 32'h80);
    push(32'h80000007, 32'h44, 32'h0, 32'h21C, 32'h1880);
    boundary(32'h40, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_redirect();
    time_compare = 1'b0;
    accept(1, 32'h21C, 32'h80000007);

    // External beats software once the synchroniser settles
    ext_irq = 1'b1; sw_irq = 1'b1; mie = 32'h888; mtvec = 32'h80;
    repeat (3) tick();
    check_eq("mip_meip_msip", mip, 32'h808);
    push(32'h8000000B, 32'h54, 32'h0, 32'h80, 32'h1880);
    boundary(32'h50, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_redirect();
    accept(0, 32'h80, 32'h8000000B);

    // Exception beats every pending interrupt
    push(32'hB, 32'h60, 32'h1234, 32'h80, 32'h1880);
    boundary(32'h60, 1'b1, 4'd11, 32'h1234, 1'b0);
    expect_redirect();
    accept(0, 32'h80, 32'hB);

    // Software beats timer; mepc+4 wraps to zero
    ext_irq = 1'b0;
    repeat (3) tick();
    time_compare = 1'b1; mtvec = 32'h201;
    push(32'h80000003, 32'h0, 32'h0, 32'h20C, 32'h1880);
    boundary(32'hFFFFFFFC, 1'b0, 4'd0, 32'h0, 1'b0);
    expect_redirect();
    sw_irq = 1'b0; time_compare = 1'b0;
    accept(0, 32'h20C, 32'h80000003);

    // Unsupported code recorded verbatim; mtvec mode 3 is direct
    mtvec = 32'h83;
    push(32'h9, 32'h200, 32'h0, 32'h80, 32'h1880);
    boundary(32'h200, 1'b1, 4'd9, 32'h0, 1'b0);
    expect_redirect();
    accept(0, 32'h80, 32'h9);

    // Global disable masks a pending timer interrupt
    mstatus = 32'h80; mie = 32'h80; time_compare = 1'b1; mtvec = 32'h80;
    boundary(32'h70, 1'b0, 4'd0, 32'h0, 1'b0);
    check_eq("masked_valid", 32'(redirect_valid), 32'd0);
    check_eq("masked_we", 32'(mstatus_we), 32'd0);
    tick();
    check_eq("masked_valid2", 32'(redirect_valid), 32'd0);
    time_compare = 1'b0;

    // Trap at 0x300, then mret back to it
    push(32'h0, 32'h300, 32'h301, 32'h80, 32'h1800);
    boundary(32'h300, 1'b1, 4'd0, 32'h301, 1'b0);
    expect_redirect();
    accept(0, 32'h80, 32'h0);
    push(32'h0, 32'h300, 32'h301, 32'h300, 32'h1888);
    boundary(32'h400, 1'b0, 4'd0, 32'h0, 1'b1);
    expect_redirect();
    accept(1, 32'h300, 32'h0);

    // Reset while waiting in REDIRECT drops everything without a clock edge
    mstatus = 32'h8;
    push(32'h2, 32'h500, 32'h11, 32'h80, 32'h1880);
    boundary(32'h500, 1'b1, 4'd2, 32'h11, 1'b0);
    expect_redirect();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_valid", 32'(redirect_valid), 32'd0);
    check_eq("arst_mcause", mcause, 32'h0);
    check_eq("arst_mepc", mepc, 32'h0);
    check_eq("arst_mbadaddr", mbadaddr, 32'h0);
    check_eq("arst_rpc", redirect_pc, 32'h0);
    check_eq("arst_we", 32'(mstatus_we), 32'd0);
    check_eq("arst_mst", mstatus_next, 32'h0);
    check_eq("arst_mip", mip, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(redirect_valid), 32'd0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
